// File: rtl/fwrisc_trap_seq.sv
`default_nettype none
// ============================================================================
// Module      : fwrisc_trap_seq
// Description : Trap entry / trap return sequencer for the fwrisc core.
//               On an exception or an enabled external interrupt it writes
//               MEPC, MCAUSE and MTVAL through the single regfile write port
//               on three consecutive cycles, then redirects fetch to mtvec.
//               On MRET it redirects fetch to the shadowed MEPC value.
//               Core writebacks share the regfile port and are stalled only
//               while the sequencer itself is writing.
// Ports       : clock, reset            - clock / async active-high reset
//               wb_valid/waddr/wdata    - core writeback request
//               wb_ready                - core writeback accepted
//               exc_req/cause/pc/tval   - exception request (level) + info
//               exc_ack                 - exception completion pulse
//               mret_req / mret_ack     - MRET request (level) / completion
//               irq, mie, meie, mtvec   - interrupt line, enables, vector
//               rd_waddr/wdata/wen      - regfile write port
//               trap, tret              - trap entry / return pulses
//               redirect_valid/pc       - fetch redirect
//               irq_taken, busy         - interrupt-trap done / not idle
// Revision    : 1.0 - initial release
// ============================================================================
module fwrisc_trap_seq #(
  parameter logic [5:0] MEPC_ADDR   = 6'h29,
  parameter logic [5:0] MCAUSE_ADDR = 6'h2A,
  parameter logic [5:0] MTVAL_ADDR  = 6'h2B
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [5:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic        wb_ready,
  input  logic        exc_req,
  input  logic [31:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  output logic        exc_ack,
  input  logic        mret_req,
  output logic        mret_ack,
  input  logic        irq,
  input  logic        mie,
  input  logic        meie,
  input  logic [31:0] mtvec,
  output logic [5:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        rd_wen,
  output logic        trap,
  output logic        tret,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        irq_taken,
  output logic        busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_W_EPC    = 3'd1;
  localparam logic [2:0] S_W_CAUSE  = 3'd2;
  localparam logic [2:0] S_W_TVAL   = 3'd3;
  localparam logic [2:0] S_REDIRECT = 3'd4;
  localparam logic [2:0] S_RET      = 3'd5;

  localparam logic [31:0] c_IRQ_CAUSE = 32'h8000_000B;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [31:0] r_epc;
  logic [31:0] r_cause;
  logic [31:0] r_tval;
  logic        r_is_irq;
  logic [31:0] r_mepc_shadow;
  logic        w_irq_pending;
  logic        w_trap_start;

  assign w_irq_pending = irq & mie & meie;
  // Exceptions and interrupts are only sampled in IDLE; an exception wins.
  assign w_trap_start  = (r_state == S_IDLE) & (exc_req | w_irq_pending);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (exc_req || w_irq_pending) begin
          w_next_state = S_W_EPC;
        end else if (mret_req) begin
          w_next_state = S_RET;
        end
      end
      S_W_EPC:    w_next_state = S_W_CAUSE;
      S_W_CAUSE:  w_next_state = S_W_TVAL;
      S_W_TVAL:   w_next_state = S_REDIRECT;
      S_REDIRECT: w_next_state = S_IDLE;
      S_RET:      w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Trap information latches and the MEPC shadow. The shadow follows every
  // regfile write to MEPC, whichever source produced it, so MRET always
  // returns to the architecturally current MEPC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_epc         <= 32'h0;
      r_cause       <= 32'h0;
      r_tval        <= 32'h0;
      r_is_irq      <= 1'b0;
      r_mepc_shadow <= 32'h0;
    end else begin
      if (w_trap_start) begin
        r_epc <= exc_pc;
        if (exc_req) begin
          r_cause  <= exc_cause;
          r_tval   <= exc_tval;
          r_is_irq <= 1'b0;
        end else begin
          r_cause  <= c_IRQ_CAUSE;
          r_tval   <= 32'h0;
          r_is_irq <= 1'b1;
        end
      end
      if (rd_wen && (rd_waddr == MEPC_ADDR)) begin
        r_mepc_shadow <= rd_wdata;
      end
    end
  end

  // Output logic
  always_comb begin
    wb_ready       = 1'b0;
    rd_wen         = 1'b0;
    rd_waddr       = wb_waddr;
    rd_wdata       = wb_wdata;
    trap           = 1'b0;
    tret           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = mtvec;
    exc_ack        = 1'b0;
    mret_ack       = 1'b0;
    irq_taken      = 1'b0;
    busy           = (r_state != S_IDLE);
    case (r_state)
      S_W_EPC: begin
        rd_wen   = 1'b1;
        rd_waddr = MEPC_ADDR;
        rd_wdata = r_epc;
        trap     = 1'b1;
      end
      S_W_CAUSE: begin
        rd_wen   = 1'b1;
        rd_waddr = MCAUSE_ADDR;
        rd_wdata = r_cause;
      end
      S_W_TVAL: begin
        rd_wen   = 1'b1;
        rd_waddr = MTVAL_ADDR;
        rd_wdata = r_tval;
      end
      S_REDIRECT: begin
        wb_ready       = 1'b1;
        rd_wen         = wb_valid;
        redirect_valid = 1'b1;
        exc_ack        = ~r_is_irq;
        irq_taken      = r_is_irq;
      end
      S_RET: begin
        wb_ready       = 1'b1;
        rd_wen         = wb_valid;
        tret           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = r_mepc_shadow;
        mret_ack       = 1'b1;
      end
      default: begin
        // IDLE: the writeback port is pass-through. A writeback offered
        // while reset is held does not reach the regfile.
        wb_ready = 1'b1;
        rd_wen   = wb_valid & ~reset;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fwrisc_trap_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwrisc_trap_seq
// Description : Self-checking bench for fwrisc_trap_seq. A queue-based
//               model of expected per-cycle outputs is compared against the
//               DUT on every falling edge; directed scenarios add literal
//               expectations for trap entry, interrupts, MRET, writeback
//               arbitration and mid-sequence reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwrisc_trap_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [5:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_ready;
  logic        exc_req;
  logic [31:0] exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        exc_ack;
  logic        mret_req;
  logic        mret_ack;
  logic        irq;
  logic        mie;
  logic        meie;
  logic [31:0] mtvec;
  logic [5:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        rd_wen;
  logic        trap;
  logic        tret;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        irq_taken;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  fwrisc_trap_seq dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_ready(wb_ready),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .exc_ack(exc_ack), .mret_req(mret_req), .mret_ack(mret_ack),
    .irq(irq), .mie(mie), .meie(meie), .mtvec(mtvec),
    .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_wen(rd_wen),
    .trap(trap), .tret(tret), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .irq_taken(irq_taken), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // One record describes what a single non-idle cycle must look like.
  typedef struct {
    logic        seq_wen;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        trap;
    logic        tret;
    logic        rv;
    logic        use_shadow;
    logic        eack;
    logic        mack;
    logic        itk;
    logic        wbr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_shadow = 32'h0;

  function automatic exp_t mk(input logic sw, input logic [5:0] a, input logic [31:0] d,
                              input logic tr, input logic tt, input logic rv,
                              input logic sh, input logic ea, input logic ma,
                              input logic it, input logic wr);
    exp_t e;
    e.seq_wen = sw; e.addr = a; e.data = d; e.trap = tr; e.tret = tt; e.rv = rv;
    e.use_shadow = sh; e.eack = ea; e.mack = ma; e.itk = it; e.wbr = wr;
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t        e;
    logic        e_busy;
    logic        e_wen;
    logic [5:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_cause;
    logic [31:0] e_tval;
    e = mk(0, 6'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    e_busy = 1'b0;
    if (reset) begin
      q.delete();
      m_shadow = 32'h0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      e_busy = 1'b1;
    end
    e_addr = e.addr;
    e_data = e.data;
    if (e.seq_wen) begin
      e_wen = 1'b1;
    end else if (e.wbr && wb_valid && !reset) begin
      e_wen  = 1'b1;
      e_addr = wb_waddr;
      e_data = wb_wdata;
    end else begin
      e_wen = 1'b0;
    end
    chk("m_busy", {31'h0, busy}, {31'h0, e_busy});
    chk("m_wb_ready", {31'h0, wb_ready}, {31'h0, e.wbr});
    chk("m_rd_wen", {31'h0, rd_wen}, {31'h0, e_wen});
    if (e_wen) begin
      chk("m_rd_waddr", {26'h0, rd_waddr}, {26'h0, e_addr});
      chk("m_rd_wdata", rd_wdata, e_data);
    end
    chk("m_trap", {31'h0, trap}, {31'h0, e.trap});
    chk("m_tret", {31'h0, tret}, {31'h0, e.tret});
    chk("m_redirect_valid", {31'h0, redirect_valid}, {31'h0, e.rv});
    chk("m_redirect_pc", redirect_pc, e.use_shadow ? m_shadow : mtvec);
    chk("m_exc_ack", {31'h0, exc_ack}, {31'h0, e.eack});
    chk("m_mret_ack", {31'h0, mret_ack}, {31'h0, e.mack});
    chk("m_irq_taken", {31'h0, irq_taken}, {31'h0, e.itk});
    if (!reset && e_wen && e_addr == 6'h29) m_shadow = e_data;
    if (!reset && !e_busy) begin
      if (exc_req || (irq && mie && meie)) begin
        e_cause = exc_req ? exc_cause : 32'h8000_000B;
        e_tval  = exc_req ? exc_tval  : 32'h0;
        q.push_back(mk(1, 6'h29, exc_pc,  1, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 6'h2A, e_cause, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 6'h2B, e_tval,  0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 6'h0, 32'h0, 0, 0, 1, 0, exc_req, 0, !exc_req, 1));
      end else if (mret_req) begin
        q.push_back(mk(0, 6'h0, 32'h0, 0, 1, 1, 1, 0, 1, 0, 1));
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    reset = 1'b1; wb_valid = 0; wb_waddr = 0; wb_wdata = 0;
    exc_req = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0;
    mret_req = 0; irq = 0; mie = 0; meie = 0; mtvec = 32'h80;
    repeat (2) tick;
    settle;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_wb_ready", {31'h0, wb_ready}, 32'h1);
    chk("rst_rd_wen", {31'h0, rd_wen}, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h80);
    reset = 1'b0;
    tick;

    // Exception trap entry
    exc_req = 1; exc_cause = 32'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    tick; settle;
    chk("exc_c1_addr", {26'h0, rd_waddr}, 32'h29);
    chk("exc_c1_data", rd_wdata, 32'h100);
    chk("exc_c1_trap", {31'h0, trap}, 32'h1);
    tick; settle;
    chk("exc_c2_addr", {26'h0, rd_waddr}, 32'h2A);
    chk("exc_c2_data", rd_wdata, 32'h2);
    tick; settle;
    chk("exc_c3_addr", {26'h0, rd_waddr}, 32'h2B);
    chk("exc_c3_data", rd_wdata, 32'hDEAD);
    tick; settle;
    chk("exc_c4_rv", {31'h0, redirect_valid}, 32'h1);
    chk("exc_c4_pc", redirect_pc, 32'h80);
    chk("exc_c4_ack", {31'h0, exc_ack}, 32'h1);
    exc_req = 0;
    tick;

    // MRET to trapped PC, then to a written-back MEPC
    mret_req = 1;
    tick; settle;
    chk("mret1_tret", {31'h0, tret}, 32'h1);
    chk("mret1_ack", {31'h0, mret_ack}, 32'h1);
    chk("mret1_pc", redirect_pc, 32'h100);
    mret_req = 0;
    tick;
    wb_valid = 1; wb_waddr = 6'h29; wb_wdata = 32'h300;
    settle;
    chk("wb_mepc_wen", {31'h0, rd_wen}, 32'h1);
    tick;
    wb_valid = 0; mret_req = 1;
    tick; settle;
    chk("mret2_pc", redirect_pc, 32'h300);
    mret_req = 0;
    tick;

    // Interrupt: masked by meie, then taken
    irq = 1; mie = 1; meie = 0; exc_pc = 32'h200;
    repeat (3) begin
      tick; settle;
      chk("irq_masked_busy", {31'h0, busy}, 32'h0);
    end
    meie = 1;
    tick; settle;
    chk("irq_c1_data", rd_wdata, 32'h200);
    irq = 0;
    tick; settle;
    chk("irq_c2_cause", rd_wdata, 32'h8000_000B);
    tick; settle;
    chk("irq_c3_tval", rd_wdata, 32'h0);
    tick; settle;
    chk("irq_c4_taken", {31'h0, irq_taken}, 32'h1);
    chk("irq_c4_exc_ack", {31'h0, exc_ack}, 32'h0);
    tick;

    // Writeback stalled by a trap
    exc_req = 1; exc_cause = 32'd7; exc_pc = 32'h400; exc_tval = 32'h11;
    tick;
    wb_valid = 1; wb_waddr = 6'h05; wb_wdata = 32'h55;
    settle;
    chk("arb_c1_ready", {31'h0, wb_ready}, 32'h0);
    chk("arb_c1_addr", {26'h0, rd_waddr}, 32'h29);
    tick; settle;
    chk("arb_c2_ready", {31'h0, wb_ready}, 32'h0);
    tick; settle;
    chk("arb_c3_ready", {31'h0, wb_ready}, 32'h0);
    tick; settle;
    chk("arb_c4_ready", {31'h0, wb_ready}, 32'h1);
    chk("arb_c4_addr", {26'h0, rd_waddr}, 32'h05);
    chk("arb_c4_data", rd_wdata, 32'h55);
    wb_valid = 0; exc_req = 0;
    tick;

    // Simultaneous exception and MRET
    exc_req = 1; mret_req = 1; exc_cause = 32'd1; exc_pc = 32'h500; exc_tval = 32'h0;
    repeat (4) tick;
    settle;
    chk("sim_c4_ack", {31'h0, exc_ack}, 32'h1);
    exc_req = 0;
    tick; settle;
    chk("sim_idle_busy", {31'h0, busy}, 32'h0);
    tick; settle;
    chk("sim_ret_tret", {31'h0, tret}, 32'h1);
    chk("sim_ret_pc", redirect_pc, 32'h500);
    mret_req = 0;
    tick;

    // Reset in W_CAUSE, then restart
    exc_req = 1; exc_cause = 32'd3; exc_pc = 32'h600; exc_tval = 32'h77;
    tick; tick; settle;
    chk("rstm_cause_addr", {26'h0, rd_waddr}, 32'h2A);
    reset = 1;
    settle;
    chk("rstm_busy", {31'h0, busy}, 32'h0);
    chk("rstm_rd_wen", {31'h0, rd_wen}, 32'h0);
    chk("rstm_exc_ack", {31'h0, exc_ack}, 32'h0);
    chk("rstm_redirect_pc", redirect_pc, 32'h80);
    tick; settle;
    chk("rstm_hold_wen", {31'h0, rd_wen}, 32'h0);
    reset = 0;
    tick; settle;
    chk("rstm_restart_data", rd_wdata, 32'h600);
    chk("rstm_restart_trap", {31'h0, trap}, 32'h1);
    repeat (3) tick;
    settle;
    chk("rstm_restart_ack", {31'h0, exc_ack}, 32'h1);
    exc_req = 0;
    repeat (2) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
